// File: rtl/gold_nic_pkg.sv
// gold_nic_pkg -- shared constants and types for the NIC.
//   PKT_W          : packet / processor data width
//   NIC_* address  : processor register map (2-bit addr)
//   buf_state_e    : per-buffer occupancy state
package gold_nic_pkg;

  localparam int PKT_W = 64;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/nic_buf.sv
// nic_buf -- one packet slot: data register plus full flag.
// Ports:
//   clk     : system clock
//   rst_ni  : synchronous active-low reset (clears flag and data)
//   set_i   : load data_i; only honoured while empty
//   clr_i   : release the slot; only honoured while full
//   data_i  : packet to load
//   data_o  : held packet (retained after release, until overwritten)
//   full_o  : slot occupied
module nic_buf
  import gold_nic_pkg::*;
(
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [0:PKT_W-1] data_i,
  output logic [0:PKT_W-1] data_o,
  output logic             full_o
);

  buf_state_e       state_q, state_d;
  logic [0:PKT_W-1] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= BUF_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A set while full is dropped, a clear while empty is a no-op; both
  // decisions use the pre-edge state only.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      BUF_EMPTY: begin
        if (set_i) begin
          state_d = BUF_FULL;
          data_d  = data_i;
        end
      end
      BUF_FULL: begin
        if (clr_i) state_d = BUF_EMPTY;
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign data_o = data_q;
  assign full_o = (state_q == BUF_FULL);

endmodule

// File: rtl/gold_nic.sv
// gold_nic -- processor-to-router network interface with one egress and
// one ingress packet buffer.
// Ports:
//   clk, reset          : clock; synchronous active-low reset
//   addr, d_in, d_out   : processor register select / write data / read data
//   nicEn, nicWrEn      : access enable, write enable
//   net_so, net_ro,
//   net_do, net_polarity: egress valid / router ready / packet / VC phase
//   net_si, net_ri,
//   net_di              : ingress valid / NIC ready / packet
module gold_nic
  import gold_nic_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [0:1]   addr,
  input  logic [0:63]  d_in,
  output logic [0:63]  d_out,
  input  logic         nicEn,
  input  logic         nicWrEn,
  output logic         net_so,
  input  logic         net_ro,
  output logic [0:63]  net_do,
  input  logic         net_polarity,
  input  logic         net_si,
  output logic         net_ri,
  input  logic [0:63]  net_di
);

  logic             rd_en, wr_en;
  logic             out_full, in_full;
  logic [0:PKT_W-1] out_buf, in_buf;
  logic             out_load, in_read, in_cap;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn &  nicWrEn;

  assign out_load = wr_en & (addr == NIC_OUT_BUF);
  assign in_read  = rd_en & (addr == NIC_IN_BUF);

  // The packet's first bit names the VC phase it must travel in.
  // Gated by reset so nothing leaves during a reset cycle.
  assign net_so = reset & out_full & net_ro & (out_buf[0] == net_polarity);
  assign net_do = out_buf;

  assign net_ri = ~in_full;
  assign in_cap = net_si & net_ri;

  nic_buf u_egress (
    .clk    (clk),
    .rst_ni (reset),
    .set_i  (out_load),
    .clr_i  (net_so),
    .data_i (d_in),
    .data_o (out_buf),
    .full_o (out_full)
  );

  nic_buf u_ingress (
    .clk    (clk),
    .rst_ni (reset),
    .set_i  (in_cap),
    .clr_i  (in_read),
    .data_i (net_di),
    .data_o (in_buf),
    .full_o (in_full)
  );

  // Status flags sit in bit 63, the least significant bit of [0:63].
  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        NIC_IN_BUF:   d_out = in_buf;
        NIC_IN_STAT:  d_out = {{(PKT_W-1){1'b0}}, in_full};
        NIC_OUT_STAT: d_out = {{(PKT_W-1){1'b0}}, out_full};
        default:      d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/gold_nic.md
GOLD_NIC -- requirements
Module: gold_nic

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, synchronous, active-low (reset==0 resets on posedge clk).
REQ-003 SHALL have port addr, input, [0:1], processor register select.
REQ-004 SHALL have port d_in, input, [0:63], processor write data.
REQ-005 SHALL have port d_out, output, [0:63], processor read data.
REQ-006 SHALL have ports nicEn and nicWrEn, input, 1 each: access enable and write enable (write when both are 1).
REQ-007 SHALL have router-side egress ports net_so (output, 1, send valid), net_ro (input, 1, router ready), net_do (output, [0:63], packet) and net_polarity (input, 1, current router VC phase).
REQ-008 SHALL have router-side ingress ports net_si (input, 1, packet valid), net_ri (output, 1, NIC ready) and net_di (input, [0:63], packet).

Function
REQ-009 SHALL hold an output-channel buffer (64b plus out_full flag) and an input-channel buffer (64b plus in_full flag).
REQ-010 SHALL decode addr as: 00 input buffer (read), 01 input status (read), 10 output buffer (write), 11 output status (read).
REQ-011 SHALL drive d_out combinationally when nicEn=1 and nicWrEn=0: addr 00 gives the input buffer; addr 01/11 give {63'b0, in_full/out_full}, status in bit 63; addr 10 gives 0.
REQ-012 SHALL drive d_out=0 when nicEn=0 or nicWrEn=1.
REQ-013 SHALL clear in_full at the clock edge of a read at addr 00; a read at addr 00 with in_full=0 returns stale data and changes no state.
REQ-014 SHALL load d_in into the output buffer and set out_full on a write at addr 10 with out_full=0; the write SHALL be silently dropped when out_full=1.
REQ-015 SHALL ignore writes to addr 00, 01 and 11.
REQ-016 SHALL drive net_so = out_full AND net_ro AND (out_buf[0] == net_polarity), with net_do = out_buf at all times.
REQ-017 SHALL clear out_full at the edge where net_so=1 (one-cycle transfer).
REQ-018 SHALL drive net_ri = NOT in_full.
REQ-019 SHALL capture net_di and set in_full at an edge where net_si=1 and net_ri=1; net_si with net_ri=0 SHALL be ignored.
REQ-020 SHALL treat each buffer as a two-state FSM (EMPTY/FULL): EMPTY->FULL on load or capture, FULL->EMPTY on transmit or processor read, no other transitions.
REQ-021 SHALL, within the same cycle, evaluate all conditions on pre-edge state: a processor read plus net_si with in_full=1 leaves in_full=0 next cycle with no capture; a write plus transmit with out_full=1 drops the write and clears out_full.
REQ-022 SHALL present a loaded packet on net_so no earlier than the cycle after the write (write-to-send latency ≥1 cycle).

Reset
REQ-023 SHALL, on reset==0 at posedge clk, clear out_full, in_full and both buffer data registers to 0, giving net_so=0, net_ri=1 and d_out=0 (with nicEn=0).
REQ-024 SHALL discard a buffered packet when reset is asserted mid-operation, with no transfer in the reset cycle.

Structure
REQ-025 SHALL place the address-map constants (NIC_IN_BUF, NIC_IN_STAT, NIC_OUT_BUF, NIC_OUT_STAT) and the packet width (64) in the shared CMP package.
REQ-026 SHALL instantiate a sub-module nic_buf (64b register plus full flag, with set/clear inputs) twice, once for egress and once for ingress.

Verification
REQ-027 SHALL cover: reset held low 3 cycles -> net_so=0, net_ri=1, reads of 01/11 = 0.
REQ-028 SHALL cover: write 64'h0000_0000_DEAD_BEEF to addr 10 with net_ro=1, polarity=0 -> net_so=1 next cycle with net_do=64'h..DEADBEEF, then out_full=0.
REQ-029 SHALL cover: write packet with bit0=1 while polarity=0 -> net_so=0; toggle polarity to 1 -> send in that cycle.
REQ-030 SHALL cover: second write to addr 10 while full with net_ro=0 -> the first packet is retained and sent later unchanged.
REQ-031 SHALL cover: net_si=1 with 64'h1234 -> net_ri=0 and status 01 reads 1; a second net_si is ignored; read addr 00 returns 64'h1234 and net_ri=1 the next cycle.
REQ-032 SHALL cover: a processor read at addr 00 in the same cycle as net_si=1 with in_full=1 -> no capture, with capture on the following cycle.
